// File: rtl/hwpe_ctrl_seq_div.sv
// Sequential unsigned restoring divider: one quotient bit per clock, NW-cycle latency.
// Quotient, remainder and divide-by-zero flag are registered and held between results.
module hwpe_ctrl_seq_div #(
    parameter int unsigned NW = 16,
    parameter int unsigned DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [NW-1:0] dividend_i,
    input  logic [DW-1:0] divisor_i,
    output logic          busy_o,
    output logic          valid_o,
    output logic [NW-1:0] quot_o,
    output logic [DW-1:0] rem_o,
    output logic          div_by_zero_o
);

    localparam int unsigned CW = $clog2(NW + 1);
    localparam logic [CW-1:0] LastCnt = CW'(NW - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state_q, state_d;
    logic [NW-1:0] q_q, q_d;
    logic [DW:0]   r_q, r_d;
    logic [DW-1:0] d_q, d_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dbz_q, dbz_d;
    logic [NW-1:0] quot_q, quot_d;
    logic [DW-1:0] rem_q, rem_d;
    logic          dbz_out_q, dbz_out_d;

    logic [DW:0]   r_shift;
    logic [DW:0]   r_sub;
    logic          r_ge;
    logic [DW:0]   r_iter;
    logic [NW-1:0] q_iter;

    always_comb begin
        r_shift = {r_q[DW-1:0], q_q[NW-1]};
        r_sub   = r_shift - {1'b0, d_q};
        r_ge    = (r_shift >= {1'b0, d_q});
        r_iter  = r_ge ? r_sub : r_shift;
        q_iter  = {q_q[NW-2:0], r_ge};
    end

    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        r_d       = r_q;
        d_d       = d_q;
        cnt_d     = cnt_q;
        dbz_d     = dbz_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dbz_out_d = dbz_out_q;

        // A start in any state wins, which aborts an in-flight run without a result.
        if (start_i) begin
            state_d = StRun;
            q_d     = dividend_i;
            r_d     = '0;
            d_d     = divisor_i;
            cnt_d   = '0;
            dbz_d   = (divisor_i == '0);
        end else begin
            case (state_q)
                StIdle: ;
                StRun: begin
                    q_d   = q_iter;
                    r_d   = r_iter;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        state_d   = StDone;
                        quot_d    = q_iter;
                        rem_d     = r_iter[DW-1:0];
                        dbz_out_d = dbz_q;
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            q_q       <= '0;
            r_q       <= '0;
            d_q       <= '0;
            cnt_q     <= '0;
            dbz_q     <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            dbz_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            r_q       <= r_d;
            d_q       <= d_d;
            cnt_q     <= cnt_d;
            dbz_q     <= dbz_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            dbz_out_q <= dbz_out_d;
        end
    end

    assign busy_o        = (state_q == StRun);
    assign valid_o       = (state_q == StDone);
    assign quot_o        = quot_q;
    assign rem_o         = rem_q;
    assign div_by_zero_o = dbz_out_q;

endmodule

// File: tb/tb_hwpe_ctrl_seq_div.sv
// Directed and back-to-back random checks for hwpe_ctrl_seq_div (NW=16, DW=8).
module tb_hwpe_ctrl_seq_div;

    localparam int unsigned NW = 16;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [NW-1:0] dividend = '0;
    logic [DW-1:0] divisor = '0;
    logic          busy;
    logic          valid;
    logic [NW-1:0] quot;
    logic [DW-1:0] rem;
    logic          dbz;

    int errors = 0;
    int checks = 0;

    hwpe_ctrl_seq_div #(.NW(NW), .DW(DW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .dividend_i   (dividend),
        .divisor_i    (divisor),
        .busy_o       (busy),
        .valid_o      (valid),
        .quot_o       (quot),
        .rem_o        (rem),
        .div_by_zero_o(dbz)
    );

    always #5 clk = ~clk;

    // Pulses start across one rising edge; returns at the falling edge after it.
    task automatic do_start(input logic [NW-1:0] a, input logic [DW-1:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Counts edges since the start edge until valid_o is seen; lat = -1 on timeout.
    task automatic wait_valid(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        forever begin
            if (busy) busy_cnt++;
            if (valid) break;
            if (lat >= 40) begin
                lat = -1;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, valid, quot, rem, dbz} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b valid=%b quot=%0d rem=%0d dbz=%b, want all 0",
                     busy, valid, quot, rem, dbz);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, bc;
        do_start(16'd1000, 8'd7);
        wait_valid(lat, bc);
        checks++;
        if (lat !== 16) begin
            errors++; $display("FAIL basic_latency: got %0d want 16", lat);
        end
        checks++;
        if (bc !== 16) begin
            errors++; $display("FAIL basic_busy_cycles: got %0d want 16", bc);
        end
        checks++;
        if (quot !== 16'd142 || rem !== 8'd6 || dbz !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got q=%0d r=%0d z=%b want q=142 r=6 z=0", quot, rem, dbz);
        end
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || quot !== 16'd142) begin
            errors++;
            $display("FAIL basic_pulse_hold: got valid=%b busy=%b q=%0d want 0 0 142",
                     valid, busy, quot);
        end
    endtask

    task automatic test_boundary();
        logic [NW-1:0] va [4] = '{16'd65535, 16'd3, 16'd255, 16'h1205};
        logic [DW-1:0] vb [4] = '{8'd255, 8'd200, 8'd1, 8'd0};
        logic [NW-1:0] vq [4] = '{16'd257, 16'd0, 16'd255, 16'hFFFF};
        logic [DW-1:0] vr [4] = '{8'd0, 8'd3, 8'd0, 8'h05};
        logic          vz [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int lat, bc;
        for (int i = 0; i < 4; i++) begin
            do_start(va[i], vb[i]);
            wait_valid(lat, bc);
            checks++;
            if (lat !== 16) begin
                errors++; $display("FAIL boundary%0d_latency: got %0d want 16", i, lat);
            end
            checks++;
            if (quot !== vq[i] || rem !== vr[i] || dbz !== vz[i]) begin
                errors++;
                $display("FAIL boundary%0d_result: got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                         i, quot, rem, dbz, vq[i], vr[i], vz[i]);
            end
        end
    endtask

    task automatic test_abort();
        int lat, bc;
        logic seen;
        seen = 1'b0;
        do_start(16'd1000, 8'd7);
        repeat (4) begin
            @(negedge clk);
            if (valid) seen = 1'b1;
        end
        checks++;
        if (seen || quot !== 16'hFFFF || dbz !== 1'b1) begin
            errors++;
            $display("FAIL abort_before: got valid_seen=%b q=%0h z=%b want 0 ffff 1", seen, quot, dbz);
        end
        start    = 1'b1;
        dividend = 16'd100;
        divisor  = 8'd9;
        @(negedge clk);
        start    = 1'b0;
        wait_valid(lat, bc);
        checks++;
        if (lat !== 16) begin
            errors++; $display("FAIL abort_latency: got %0d want 16", lat);
        end
        checks++;
        if (quot !== 16'd11 || rem !== 8'd1 || dbz !== 1'b0) begin
            errors++;
            $display("FAIL abort_result: got q=%0d r=%0d z=%b want q=11 r=1 z=0", quot, rem, dbz);
        end
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL abort_extra_valid: got %b want 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        do_start(16'd1000, 8'd7);
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, valid, quot, rem, dbz} !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: got busy=%b valid=%b q=%0d r=%0d z=%b want all 0",
                     busy, valid, quot, rem, dbz);
        end
        @(negedge clk);
        rst = 1'b0;
        do_start(16'd50, 8'd6);
        wait_valid(lat, bc);
        checks++;
        if (lat !== 16 || quot !== 16'd8 || rem !== 8'd2 || dbz !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after: got lat=%0d q=%0d r=%0d z=%b want 16 8 2 0",
                     lat, quot, rem, dbz);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic [NW-1:0] a, na;
        logic [DW-1:0] b, nb;
        logic [NW-1:0] eq;
        logic [DW-1:0] er;
        a = 16'($urandom_range(0, 65535));
        b = 8'($urandom_range(1, 255));
        do_start(a, b);
        for (int i = 0; i < 20; i++) begin
            wait_valid(lat, bc);
            na = 16'($urandom_range(0, 65535));
            nb = (i == 6) ? 8'd0 : 8'($urandom_range(1, 255));
            // Next operation starts while the current one sits in DONE.
            if (i < 19) begin
                start    = 1'b1;
                dividend = na;
                divisor  = nb;
            end
            eq = (b != 0) ? a / {8'd0, b} : 16'hFFFF;
            er = (b != 0) ? 8'(a % {8'd0, b}) : a[DW-1:0];
            checks++;
            if (lat !== 16 || quot !== eq || rem !== er || dbz !== (b == 0)) begin
                errors++;
                $display("FAIL b2b%0d_result: %0d/%0d got lat=%0d q=%0d r=%0d z=%b want 16 %0d %0d %b",
                         i, a, b, lat, quot, rem, dbz, eq, er, b == 0);
            end
            if (b != 0) begin
                checks++;
                if (32'(quot) * 32'(b) + 32'(rem) != 32'(a) || rem >= b) begin
                    errors++;
                    $display("FAIL b2b%0d_identity: %0d/%0d got q=%0d r=%0d", i, a, b, quot, rem);
                end
            end
            @(negedge clk);
            start = 1'b0;
            a = na;
            b = nb;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hwpe_ctrl_seq_div.md
# hwpe_ctrl_seq_div

Sequential unsigned restoring divider for the HWPE control path, the inverse of the shift-add sequential multiplier. It takes an NW-bit dividend and a DW-bit divisor on a start pulse and produces one quotient bit per clock. Quotient and remainder are available NW cycles later. It is used by controllers and address generators that need to recover loop counts, tile counts or strides from products without instantiating a combinational divider.

## Interface

Parameters:

- NW, default 16: dividend and quotient width, at least 2.
- DW, default 8: divisor and remainder width, 1 to NW.

Ports:

- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  single-cycle request; operands are captured on the same edge.
- dividend_i  input  NW  unsigned dividend.
- divisor_i  input  DW  unsigned divisor.
- busy_o  output  1  high while an iteration is in progress.
- valid_o  output  1  single-cycle pulse when the result is ready.
- quot_o  output  NW  quotient; held until the next start.
- rem_o  output  DW  remainder; held until the next start.
- div_by_zero_o  output  1  high when the divisor was 0; valid with the result and held with it.

## Operation

- States:
  - IDLE: accepts start.
  - RUN: NW iterations.
  - DONE: one cycle, valid_o high.
  - DONE returns to IDLE.
- On start_i:
  - Load the dividend into the quotient shift register.
  - Load the divisor into the divisor register.
  - Clear the partial remainder, which is DW+1 bits.
  - Clear the iteration counter, which is $clog2(NW+1) bits.
  - Latch the flag (divisor_i == 0).
  - Go to RUN.
- Each RUN cycle:
  - r' = {r[DW-1:0], q[NW-1]}.
  - q is shifted left by one.
  - If r' >= {1'b0, divisor}: r = r' - divisor and q[0] = 1. Otherwise r = r' and q[0] = 0.
  - Counter increments; after NW iterations go to DONE.
- Width rules:
  - All arithmetic is unsigned.
  - The remainder is always less than the divisor, so it fits DW bits. The MSB of r is never set after a restore step.
  - No truncation of the quotient: the NW-bit quotient is exact.
- Divide by zero:
  - The iteration runs normally and yields quot = all ones and rem = dividend[DW-1:0].
  - div_by_zero_o = 1.
  - Latency is unchanged, so timing is data-independent.
- start_i in RUN aborts the current division, reloads the new operands and restarts the count. No valid_o is produced for the aborted operation.
- start_i in DONE is accepted: valid_o for the old result still pulses this cycle, and the new operation starts.
- quot_o, rem_o and div_by_zero_o change only on DONE entry and on reset. They are stable between results.
- busy_o is high in RUN only.

## Timing

- Start captured at edge E0.
- Iterations occur on edges E1..ENW.
- DONE is entered at ENW; valid_o is high during the cycle between ENW and ENW+1.
- Latency from the start edge to valid_o is NW cycles, matching the multiplier (NW+1 cycles per op including the start cycle when back-to-back).
- Maximum throughput is one division per NW+1 cycles.
- On reset assertion (asynchronous, in any state, including mid-RUN):
  - State goes to IDLE.
  - busy_o = 0, valid_o = 0, quot_o = 0, rem_o = 0, div_by_zero_o = 0, and all internal registers are 0.
  - The in-flight operation is lost.
- Reset deassertion needs no synchronizer inside the block. start_i must not be asserted on the first edge after deassertion.
- No outputs are combinational from inputs. All outputs are registered.

## Test plan

- NW=16, DW=8, dividend 1000, divisor 7 → valid_o exactly 16 cycles after the start edge, quot_o=142, rem_o=6, div_by_zero_o=0; busy_o high for 16 cycles.
- Boundary values:
  - 65535 / 255 → quot 257, rem 0.
  - 3 / 200 → quot 0, rem 3.
  - 255 / 1 → quot 255, rem 0.
- Divisor 0 with dividend 0x1205 → quot 0xFFFF, rem 0x05, div_by_zero_o=1, same 16-cycle latency.
- Abort: start 1000/7, then start 100/9 five cycles later → single valid_o, 16 cycles after the second start, with quot 11, rem 1; no pulse for the first operation.
- Reset mid-operation: assert rst_i 8 cycles into a division → all outputs 0 immediately without waiting for a clock edge. After release, a new 50/6 gives quot 8, rem 2.
- Random regression:
  - Back-to-back random operands, start every NW+1 cycles, start asserted in DONE.
  - Check on every valid_o: quot_o*divisor + rem_o == dividend and rem_o < divisor (for a non-zero divisor); fatal on mismatch.
